iot_packet_receiver: RTL

UART receiver and frame decoder for the sensor-controller telemetry link. It is the far end of tx_serial: it recovers 8N1 bytes at 115200 baud and parses the fixed 9-byte frame 7E | ID | LEN | TS_H | TS_L | D_H | D_L | CKSUM | 7E. Validated packets are presented on a valid/ready interface, with error flags and counters. It serves as the gateway-side RX block and as a synthesizable scoreboard front-end.

---
 rtl/iot_sensor_pkg.sv | 20 ++
 rtl/iot_uart_rx.sv | 88 ++++++++
 rtl/iot_packet_receiver.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/iot_sensor_pkg.sv
// Shared constants and state types for the sensor telemetry link.
// Frame layout: 7E | ID | LEN | TS_H | TS_L | D_H | D_L | CKSUM | 7E.
package iot_sensor_pkg;

    localparam logic [7:0] PKT_FLAG = 8'h7E;
    localparam logic [7:0] PKT_LEN  = 8'd9;

    localparam logic [1:0] SENSOR_TEMP   = 2'd0;
    localparam logic [1:0] SENSOR_HUM    = 2'd1;
    localparam logic [1:0] SENSOR_MOTION = 2'd2;

    typedef enum logic [3:0] {
        PS_HUNT, PS_ID, PS_LEN, PS_TSH, PS_TSL, PS_DH, PS_DL, PS_CK, PS_END
    } pkt_rx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } uart_rx_state_t;

endpackage

// File: rtl/iot_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, centre sampling, one-cycle
// byte strobe on a good stop bit and frame_err pulse on a low stop bit.
module iot_uart_rx
    import iot_sensor_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       frame_err
);

    localparam int CPB   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W = $clog2(CPB + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CPB - 1);

    logic sync1, sync2, rx_prev;
    uart_rx_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic strobe_d, ferr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            rx_prev   <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= rx_serial;
            sync2     <= sync1;
            rx_prev   <= sync2;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_strobe <= strobe_d;
            frame_err <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev && !sync2) state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_M1) begin
                // Line back high at mid start bit means it was a glitch
                cnt_d   = '0;
                bit_d   = '0;
                state_d = sync2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL_M1) begin
                cnt_d   = '0;
                shift_d = {sync2, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == FULL_M1) begin
                state_d  = RX_IDLE;
                strobe_d = sync2;
                ferr_d   = !sync2;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/iot_packet_receiver.sv
// Telemetry frame decoder: parses 9-byte frames from the UART receiver,
// verifies length/checksum/end flag and presents packets on valid/ready.
module iot_packet_receiver
    import iot_sensor_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_serial,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [1:0]  sensor_id,
    output logic [15:0] timestamp,
    output logic [15:0] sensor_data,
    output logic [7:0]  pkt_count,
    output logic [7:0]  err_count,
    output logic        cksum_err,
    output logic        len_err,
    output logic        sync_err,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [31:0] TMO_M1 =
        32'(TIMEOUT_BITS * (CLK_FREQ_HZ / BAUD_RATE) - 1);

    logic [7:0] rx_byte;
    logic       rx_strobe, rx_ferr;

    iot_uart_rx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE)) u_uart_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_serial (rx_serial),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .frame_err (rx_ferr)
    );

    pkt_rx_state_t pstate_q, pstate_d;
    logic [1:0]  id_q;
    logic [15:0] ts_q, data_q;
    logic [7:0]  csum_q;
    logic        ck_fail_q;
    logic [31:0] tmo_cnt;
    logic        tmo_hit, in_frame;
    logic        ck_e, len_e, sync_e, commit, ovr_e, accept, err_any;

    assign in_frame = (pstate_q != PS_HUNT) && (pstate_q != PS_ID);
    assign tmo_hit  = in_frame && (tmo_cnt == TMO_M1);
    assign accept   = pkt_valid && pkt_ready;
    assign ovr_e    = commit && pkt_valid && !pkt_ready;
    assign err_any  = ck_e | len_e | sync_e | rx_ferr | ovr_e;

    always_comb begin
        pstate_d = pstate_q;
        ck_e     = 1'b0;
        len_e    = 1'b0;
        sync_e   = 1'b0;
        commit   = 1'b0;
        if (rx_ferr && pstate_q != PS_HUNT) begin
            pstate_d = PS_HUNT;
        end else if (tmo_hit) begin
            sync_e   = 1'b1;
            pstate_d = PS_HUNT;
        end else if (rx_strobe) begin
            case (pstate_q)
                PS_HUNT: if (rx_byte == PKT_FLAG) pstate_d = PS_ID;
                PS_ID:   if (rx_byte != PKT_FLAG) pstate_d = PS_LEN;
                PS_LEN: begin
                    len_e    = (rx_byte != PKT_LEN);
                    pstate_d = len_e ? PS_HUNT : PS_TSH;
                end
                PS_TSH:  pstate_d = PS_TSL;
                PS_TSL:  pstate_d = PS_DH;
                PS_DH:   pstate_d = PS_DL;
                PS_DL:   pstate_d = PS_CK;
                PS_CK:   pstate_d = PS_END;
                PS_END: begin
                    pstate_d = PS_HUNT;
                    if (rx_byte != PKT_FLAG) sync_e = 1'b1;
                    else if (ck_fail_q)      ck_e   = 1'b1;
                    else                     commit = 1'b1;
                end
                default: pstate_d = PS_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pstate_q    <= PS_HUNT;
            id_q        <= '0;
            ts_q        <= '0;
            data_q      <= '0;
            csum_q      <= '0;
            ck_fail_q   <= 1'b0;
            tmo_cnt     <= '0;
            pkt_valid   <= 1'b0;
            sensor_id   <= '0;
            timestamp   <= '0;
            sensor_data <= '0;
            pkt_count   <= '0;
            err_count   <= '0;
            cksum_err   <= 1'b0;
            len_err     <= 1'b0;
            sync_err    <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            pstate_q  <= pstate_d;
            cksum_err <= ck_e;
            len_err   <= len_e;
            sync_err  <= sync_e;
            frame_err <= rx_ferr;
            overrun   <= ovr_e;

            tmo_cnt <= (rx_strobe || !in_frame) ? '0 : tmo_cnt + 1'b1;

            if (rx_strobe) begin
                case (pstate_q)
                    PS_ID: begin
                        id_q   <= rx_byte[1:0];
                        csum_q <= rx_byte;
                    end
                    PS_LEN: csum_q <= csum_q ^ rx_byte;
                    PS_TSH: begin ts_q[15:8]   <= rx_byte; csum_q <= csum_q ^ rx_byte; end
                    PS_TSL: begin ts_q[7:0]    <= rx_byte; csum_q <= csum_q ^ rx_byte; end
                    PS_DH:  begin data_q[15:8] <= rx_byte; csum_q <= csum_q ^ rx_byte; end
                    PS_DL:  begin data_q[7:0]  <= rx_byte; csum_q <= csum_q ^ rx_byte; end
                    PS_CK:  ck_fail_q <= (rx_byte != csum_q);
                    default: ;
                endcase
            end

            // A new packet may replace one that is being accepted this cycle
            if (commit && (!pkt_valid || pkt_ready)) begin
                pkt_valid   <= 1'b1;
                sensor_id   <= id_q;
                timestamp   <= ts_q;
                sensor_data <= data_q;
            end else if (accept) begin
                pkt_valid <= 1'b0;
            end

            if (accept) pkt_count <= pkt_count + 1'b1;
            if (err_any && err_count != 8'hFF) err_count <= err_count + 1'b1;
        end
    end

endmodule
